// File: rtl/m_ext_pkg.sv
// Shared encodings, state type and constants for the RV32M execute-stage sequencer.
package m_ext_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;
  localparam int unsigned F3_W  = 3;
  localparam int unsigned OP_W  = 2;

  localparam logic [F3_W-1:0] F3_MUL    = 3'b000;
  localparam logic [F3_W-1:0] F3_MULH   = 3'b001;
  localparam logic [F3_W-1:0] F3_MULHSU = 3'b010;
  localparam logic [F3_W-1:0] F3_MULHU  = 3'b011;
  localparam logic [F3_W-1:0] F3_DIV    = 3'b100;
  localparam logic [F3_W-1:0] F3_DIVU   = 3'b101;
  localparam logic [F3_W-1:0] F3_REM    = 3'b110;
  localparam logic [F3_W-1:0] F3_REMU   = 3'b111;

  // Unit opcodes are funct3[1:0]; multiplier and divider share the encoding space.
  localparam logic [OP_W-1:0] OP_MUL    = 2'b00;
  localparam logic [OP_W-1:0] OP_MULH   = 2'b01;
  localparam logic [OP_W-1:0] OP_MULHSU = 2'b10;
  localparam logic [OP_W-1:0] OP_MULHU  = 2'b11;
  localparam logic [OP_W-1:0] OP_DIV    = 2'b00;
  localparam logic [OP_W-1:0] OP_DIVU   = 2'b01;
  localparam logic [OP_W-1:0] OP_REM    = 2'b10;
  localparam logic [OP_W-1:0] OP_REMU   = 2'b11;

  localparam logic [XLEN-1:0] INT_MIN  = 32'h8000_0000;
  localparam logic [XLEN-1:0] ALL_ONES = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MUL_WAIT = 3'd1,
    DIV_WAIT = 3'd2,
    DRAIN    = 3'd3,
    RESP     = 3'd4
  } ctrl_state_t;

endpackage

// File: rtl/m_ext_special_case.sv
// Combinational detector for M-ops whose result is known without running a unit.
module m_ext_special_case
  import m_ext_pkg::*;
(
  input  logic [F3_W-1:0] funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            hit,
  output logic [XLEN-1:0] value
);

  logic rs1_zero;
  logic rs2_zero;
  logic overflow;

  assign rs1_zero = (rs1 == '0);
  assign rs2_zero = (rs2 == '0);
  assign overflow = (rs1 == INT_MIN) && (rs2 == ALL_ONES);

  // Division by zero takes precedence over signed overflow; rs2 cannot be both.
  always_comb begin
    hit   = 1'b0;
    value = '0;
    if (!funct3[2]) begin
      hit = rs1_zero || rs2_zero;
    end else if (rs2_zero) begin
      hit   = 1'b1;
      value = funct3[1] ? rs1 : ALL_ONES;
    end else if (overflow && (funct3[1:0] == OP_DIV)) begin
      hit   = 1'b1;
      value = INT_MIN;
    end else if (overflow && (funct3[1:0] == OP_REM)) begin
      hit   = 1'b1;
      value = '0;
    end
  end

endmodule

// File: rtl/m_ext_controller.sv
// RV32M execute-stage sequencer: resolves trivial cases locally, otherwise launches
// the shared multiplier/divider, stalls until done and emits one tagged writeback.
module m_ext_controller
  import m_ext_pkg::*;
#(
  parameter bit          FAST_PATH  = 1'b1,
  parameter int unsigned MAX_CYCLES = 40,
  parameter int unsigned CNT_W      = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic [F3_W-1:0]  funct3,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic [REG_W-1:0] rd_addr,
  input  logic             flush,
  output logic             mul_start,
  output logic [OP_W-1:0]  mul_opcode,
  output logic [XLEN-1:0]  mul_op1,
  output logic [XLEN-1:0]  mul_op2,
  input  logic             mul_done,
  input  logic [XLEN-1:0]  mul_result,
  output logic             div_start,
  output logic [OP_W-1:0]  div_opcode,
  output logic [XLEN-1:0]  div_op1,
  output logic [XLEN-1:0]  div_op2,
  input  logic             div_done,
  input  logic [XLEN-1:0]  div_result,
  output logic             stall,
  output logic             res_valid,
  output logic [XLEN-1:0]  res_data,
  output logic [REG_W-1:0] res_rd,
  output logic             busy,
  output logic             timeout_err
);

  ctrl_state_t      state;
  ctrl_state_t      state_next;
  logic [XLEN-1:0]  op_a;
  logic [XLEN-1:0]  op_a_next;
  logic [XLEN-1:0]  op_b;
  logic [XLEN-1:0]  op_b_next;
  logic [F3_W-1:0]  op_f3;
  logic [F3_W-1:0]  op_f3_next;
  logic [REG_W-1:0] rd_q;
  logic [REG_W-1:0] rd_next;
  logic [XLEN-1:0]  res_q;
  logic [XLEN-1:0]  res_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             mul_start_next;
  logic             div_start_next;
  logic             timeout_next;

  logic             sc_hit;
  logic [XLEN-1:0]  sc_value;
  logic             unit_done;
  logic [XLEN-1:0]  unit_result;
  logic             wd_expired;

  generate
    if (FAST_PATH) begin : g_fast
      m_ext_special_case u_special_case (
        .funct3 (funct3),
        .rs1    (rs1_data),
        .rs2    (rs2_data),
        .hit    (sc_hit),
        .value  (sc_value)
      );
    end else begin : g_no_fast
      assign sc_hit   = 1'b0;
      assign sc_value = '0;
    end
  endgenerate

  // The registered funct3[2] selects the unit in flight, also while draining.
  assign unit_done   = op_f3[2] ? div_done : mul_done;
  assign unit_result = op_f3[2] ? div_result : mul_result;
  assign wd_expired  = (cnt >= CNT_W'(MAX_CYCLES - 1));

  assign mul_opcode = op_f3[1:0];
  assign div_opcode = op_f3[1:0];
  assign mul_op1    = op_a;
  assign mul_op2    = op_b;
  assign div_op1    = op_a;
  assign div_op2    = op_b;
  assign res_data   = res_q;
  assign res_rd     = rd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      op_a        <= '0;
      op_b        <= '0;
      op_f3       <= '0;
      rd_q        <= '0;
      res_q       <= '0;
      cnt         <= '0;
      mul_start   <= 1'b0;
      div_start   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_next;
      op_a        <= op_a_next;
      op_b        <= op_b_next;
      op_f3       <= op_f3_next;
      rd_q        <= rd_next;
      res_q       <= res_next;
      cnt         <= cnt_next;
      mul_start   <= mul_start_next;
      div_start   <= div_start_next;
      timeout_err <= timeout_next;
    end
  end

  // Priority inside a wait state: flush, then unit done, then watchdog.
  always_comb begin
    state_next     = state;
    op_a_next      = op_a;
    op_b_next      = op_b;
    op_f3_next     = op_f3;
    rd_next        = rd_q;
    res_next       = res_q;
    cnt_next       = '0;
    mul_start_next = 1'b0;
    div_start_next = 1'b0;
    timeout_next   = 1'b0;
    stall          = 1'b0;
    busy           = 1'b0;
    res_valid      = 1'b0;

    unique case (state)
      IDLE: begin
        if (ex_valid && !flush) begin
          stall      = 1'b1;
          op_a_next  = rs1_data;
          op_b_next  = rs2_data;
          op_f3_next = funct3;
          rd_next    = rd_addr;
          if (sc_hit) begin
            res_next   = sc_value;
            state_next = RESP;
          end else if (funct3[2]) begin
            div_start_next = 1'b1;
            state_next     = DIV_WAIT;
          end else begin
            mul_start_next = 1'b1;
            state_next     = MUL_WAIT;
          end
        end
      end

      MUL_WAIT, DIV_WAIT: begin
        stall    = 1'b1;
        busy     = 1'b1;
        cnt_next = cnt + CNT_W'(1);
        if (flush) begin
          state_next = unit_done ? IDLE : DRAIN;
        end else if (unit_done) begin
          res_next   = unit_result;
          state_next = RESP;
        end else if (wd_expired) begin
          timeout_next = 1'b1;
          state_next   = IDLE;
        end
      end

      DRAIN: begin
        busy     = 1'b1;
        stall    = ex_valid;
        cnt_next = cnt + CNT_W'(1);
        if (unit_done) begin
          state_next = IDLE;
        end else if (wd_expired) begin
          timeout_next = 1'b1;
          state_next   = IDLE;
        end
      end

      RESP: begin
        res_valid  = !flush;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_m_ext_controller.sv
// Directed bench for m_ext_controller with behavioural multiplier/divider models.
module tb_m_ext_controller;
  import m_ext_pkg::*;

  localparam int unsigned MAXC = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic [4:0]  rd_addr = '0;
  logic        flush = 1'b0;
  logic        mul_start, div_start, stall, res_valid, busy, timeout_err;
  logic [1:0]  mul_opcode, div_opcode;
  logic [31:0] mul_op1, mul_op2, div_op1, div_op2, res_data;
  logic [4:0]  res_rd;
  logic        mul_done = 1'b0;
  logic        div_done = 1'b0;
  logic [31:0] mul_result = '0;
  logic [31:0] div_result = '0;

  always #5 clk = ~clk;

  m_ext_controller #(.FAST_PATH(1'b1), .MAX_CYCLES(MAXC), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .funct3(funct3),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_addr(rd_addr), .flush(flush),
    .mul_start(mul_start), .mul_opcode(mul_opcode), .mul_op1(mul_op1), .mul_op2(mul_op2),
    .mul_done(mul_done), .mul_result(mul_result),
    .div_start(div_start), .div_opcode(div_opcode), .div_op1(div_op1), .div_op2(div_op2),
    .div_done(div_done), .div_result(div_result),
    .stall(stall), .res_valid(res_valid), .res_data(res_data), .res_rd(res_rd),
    .busy(busy), .timeout_err(timeout_err)
  );

  int errors = 0;
  int checks = 0;
  int mul_lat = 33;
  int div_lat = 10;
  bit div_never = 1'b0;
  int mul_cnt = 0;
  int div_cnt = 0;
  int mul_starts = 0;
  int div_starts = 0;
  int res_cnt = 0;
  int overlap = 0;

  function automatic logic [31:0] mul_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = {{32{((op == 2'b01) || (op == 2'b10)) && a[31]}}, a};
    eb = {{32{(op == 2'b01) && b[31]}}, b};
    p  = ea * eb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] div_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (op)
      2'b00:   r = 32'($signed(a) / $signed(b));
      2'b01:   r = a / b;
      2'b10:   r = 32'($signed(a) % $signed(b));
      default: r = a % b;
    endcase
    return r;
  endfunction

  // Unit models: done pulses LAT cycles after the cycle carrying the start pulse.
  always @(negedge clk) begin
    mul_done = 1'b0;
    div_done = 1'b0;
    if (mul_cnt > 0) begin
      mul_cnt--;
      if (mul_cnt == 0) begin
        mul_done   = 1'b1;
        mul_result = mul_model(mul_opcode, mul_op1, mul_op2);
      end
    end
    if (div_cnt > 0) begin
      div_cnt--;
      if (div_cnt == 0) begin
        div_done   = 1'b1;
        div_result = div_model(div_opcode, div_op1, div_op2);
      end
    end
    if (mul_start) begin
      if (mul_cnt > 0 || div_cnt > 0) overlap++;
      mul_starts++;
      mul_cnt = mul_lat;
    end
    if (div_start) begin
      if (mul_cnt > 0 || div_cnt > 0) overlap++;
      div_starts++;
      if (!div_never) div_cnt = div_lat;
    end
    if (res_valid) res_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
    ex_valid = v;
    funct3   = f;
    rs1_data = a;
    rs2_data = b;
    rd_addr  = rd;
  endtask

  typedef struct packed {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int ms, ds, r0, stall_n, first_start, k;
    bit got, acc, rv, hit;

    vecs[0] = '{F3_MUL,    32'h0000_0000, 32'h0000_1234, 5'd1,  32'h0000_0000};
    vecs[1] = '{F3_MULH,   32'h0000_0005, 32'h0000_0000, 5'd2,  32'h0000_0000};
    vecs[2] = '{F3_DIVU,   32'h0000_0055, 32'h0000_0000, 5'd3,  32'hFFFF_FFFF};
    vecs[3] = '{F3_DIV,    32'h0000_0007, 32'h0000_0000, 5'd4,  32'hFFFF_FFFF};
    vecs[4] = '{F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd5,  32'h0000_0000};
    vecs[5] = '{F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd6,  32'h8000_0000};
    vecs[6] = '{F3_REMU,   32'h0000_1234, 32'h0000_0000, 5'd7,  32'h0000_1234};
    vecs[7] = '{F3_REM,    32'hFFFF_FFF7, 32'h0000_0000, 5'd31, 32'hFFFF_FFF7};

    // Reset state
    repeat (3) tick();
    #1;
    chk("rst_ctrl", 32'({mul_start, div_start, stall, res_valid, busy, timeout_err}), 0);
    chk("rst_tags", 32'({res_rd, mul_opcode, div_opcode}), 0);
    chk("rst_data", res_data, 0);
    chk("rst_ops", mul_op1 | mul_op2 | div_op1 | div_op2, 0);
    tick();
    rst_n = 1'b1;

    // Fast-path table
    for (int i = 0; i < 8; i++) begin
      ms = mul_starts;
      ds = div_starts;
      tick();
      drive(1'b1, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd);
      #1;
      chk($sformatf("v%0d_accept_stall", i), 32'(stall), 1);
      tick();
      drive(1'b0, 3'b000, 0, 0, 0);
      #1;
      chk($sformatf("v%0d_res_valid", i), 32'(res_valid), 1);
      chk($sformatf("v%0d_res_data", i), res_data, vecs[i].exp);
      chk($sformatf("v%0d_res_rd", i), 32'(res_rd), 32'(vecs[i].rd));
      chk($sformatf("v%0d_resp_stall", i), 32'(stall), 0);
      tick();
      #1;
      chk($sformatf("v%0d_single_strobe", i), 32'(res_valid), 0);
      chk($sformatf("v%0d_no_start", i), 32'((mul_starts - ms) + (div_starts - ds)), 0);
    end

    // MUL 7x6 through the multiplier, latency 33
    mul_lat = 33;
    ms = mul_starts;
    tick();
    drive(1'b1, F3_MUL, 7, 6, 5'd5);
    #1;
    stall_n = stall ? 1 : 0;
    got = 1'b0;
    first_start = -1;
    for (int i = 0; i < 100 && !got; i++) begin
      tick();
      drive(1'b0, 3'b000, 0, 0, 0);
      #1;
      if (mul_start && first_start < 0) first_start = i;
      if (i == 10) chk("mul_busy_wait", 32'(busy), 1);
      if (res_valid) got = 1'b1;
      else if (stall) stall_n++;
    end
    chk("mul_got_result", 32'(got), 1);
    chk("mul_start_next_cycle", 32'(first_start), 0);
    chk("mul_stall_cycles", 32'(stall_n), 35);
    chk("mul_res_data", res_data, 42);
    chk("mul_res_rd", 32'(res_rd), 5);
    chk("mul_ops_held", {mul_op1[15:0], mul_op2[15:0]}, {16'd7, 16'd6});
    tick();
    #1;
    chk("mul_one_start", 32'(mul_starts - ms), 1);

    // DIVU 20/3 through the divider, latency 10
    ms = mul_starts;
    ds = div_starts;
    tick();
    drive(1'b1, F3_DIVU, 20, 3, 5'd9);
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      tick();
      drive(1'b0, 3'b000, 0, 0, 0);
      #1;
      if (res_valid) got = 1'b1;
    end
    chk("divu_res_data", res_data, 6);
    chk("divu_res_rd", 32'(res_rd), 9);
    tick();
    #1;
    chk("divu_starts", 32'({8'(mul_starts - ms), 8'(div_starts - ds)}), 32'h0001);

    // flush in IDLE blocks acceptance
    tick();
    drive(1'b1, F3_DIV, 10, 2, 5'd1);
    flush = 1'b1;
    #1;
    chk("idle_flush_stall", 32'(stall), 0);
    tick();
    drive(1'b0, 3'b000, 0, 0, 0);
    flush = 1'b0;
    #1;
    chk("idle_flush_nothing", 32'({busy, res_valid, mul_start, div_start}), 0);

    // flush in RESP suppresses the strobe
    r0 = res_cnt;
    tick();
    drive(1'b1, F3_DIVU, 5, 0, 5'd2);
    tick();
    drive(1'b0, 3'b000, 0, 0, 0);
    flush = 1'b1;
    #1;
    chk("resp_flush_valid", 32'(res_valid), 0);
    tick();
    flush = 1'b0;
    #1;
    chk("resp_flush_idle", 32'({busy, res_valid, stall}), 0);
    chk("resp_flush_count", 32'(res_cnt - r0), 0);

    // MULHU flushed mid-flight, younger MUL 3x5 waits in DRAIN
    mul_lat = 33;
    ms = mul_starts;
    r0 = res_cnt;
    tick();
    drive(1'b1, F3_MULHU, 32'hFFFF_FFFF, 2, 5'd6);
    repeat (5) begin
      tick();
      drive(1'b0, 3'b000, 0, 0, 0);
    end
    tick();
    flush = 1'b1;
    #1;
    chk("flush_wait_busy", 32'(busy), 1);
    tick();
    flush = 1'b0;
    #1;
    chk("drain_busy_nostall", 32'({busy, stall}), 32'b10);
    mul_lat = 4;
    drive(1'b1, F3_MUL, 3, 5, 5'd7);
    #1;
    chk("drain_stall_younger", 32'(stall), 1);
    acc = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      tick();
      if (acc) drive(1'b0, 3'b000, 0, 0, 0);
      #1;
      if (!acc && !busy && stall) begin
        acc = 1'b1;
        chk("drain_no_result", 32'(res_cnt - r0), 0);
      end
      if (res_valid) got = 1'b1;
    end
    chk("after_drain_accept", 32'(acc), 1);
    chk("after_drain_data", res_data, 15);
    chk("after_drain_rd", 32'(res_rd), 7);
    tick();
    #1;
    chk("after_drain_starts", 32'(mul_starts - ms), 2);
    chk("no_start_in_flight", 32'(overlap), 0);

    // Divider never finishes: watchdog
    div_never = 1'b1;
    ds = div_starts;
    r0 = res_cnt;
    tick();
    drive(1'b1, F3_DIV, 100, 7, 5'd3);
    #1;
    chk("to_accept_stall", 32'(stall), 1);
    k = 0;
    hit = 1'b0;
    rv = 1'b0;
    for (int i = 1; i <= 100 && !hit; i++) begin
      tick();
      drive(1'b0, 3'b000, 0, 0, 0);
      #1;
      if (res_valid) rv = 1'b1;
      if (timeout_err) begin
        hit = 1'b1;
        k = i;
        chk("to_released", 32'({stall, busy}), 0);
      end
    end
    chk("to_cycle", 32'(k), MAXC + 1);
    chk("to_no_result", 32'({rv, 8'(res_cnt - r0)}), 0);
    tick();
    #1;
    chk("to_single_pulse", 32'(timeout_err), 0);
    chk("to_one_start", 32'(div_starts - ds), 1);
    div_never = 1'b0;

    // Reset during MUL_WAIT; the later done must be ignored
    mul_lat = 33;
    r0 = res_cnt;
    tick();
    drive(1'b1, F3_MUL, 7, 6, 5'd4);
    repeat (10) begin
      tick();
      drive(1'b0, 3'b000, 0, 0, 0);
    end
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ctrl", 32'({mul_start, div_start, stall, res_valid, busy, timeout_err}), 0);
    chk("mid_rst_tags", 32'({res_rd, mul_opcode, div_opcode}), 0);
    chk("mid_rst_data", res_data | mul_op1 | mul_op2, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    hit = 1'b0;
    repeat (40) begin
      tick();
      #1;
      if (busy || res_valid || stall) hit = 1'b1;
    end
    chk("post_rst_quiet", 32'(hit), 0);
    chk("post_rst_no_result", 32'(res_cnt - r0), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/m_ext_controller.md
Name: m_ext_controller

Overview:
- Execute-stage sequencer for the RV32M extension.
- Decodes funct3 of an M-type instruction and either resolves special cases locally or launches the shared iterative multiplier or divider with a one-cycle start pulse.
- Stalls the pipeline while the unit runs and delivers one tagged result to writeback.
- Handles flushes that arrive while a unit is still running.

Parameters:
- FAST_PATH, 1: enables local resolution of zero-operand, divide-by-zero and signed-overflow cases.
- MAX_CYCLES, 40: watchdog limit on cycles spent waiting for a unit done.
- CNT_W, 6: width of the watchdog counter; must satisfy 2^CNT_W > MAX_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ex_valid  in  1  valid M-type instruction present in EX.
- funct3  in  3  M-op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_data  in  32  operand A.
- rs2_data  in  32  operand B.
- rd_addr  in  5  destination register tag.
- flush  in  1  kill the EX-stage instruction.
- mul_start  out  1  one-cycle start pulse to the multiplier.
- mul_opcode  out  2  funct3[1:0] passed to the multiplier.
- mul_op1  out  32  registered operand A to the multiplier.
- mul_op2  out  32  registered operand B to the multiplier.
- mul_done  in  1  multiplier completion pulse.
- mul_result  in  32  multiplier result, valid with mul_done.
- div_start  out  1  one-cycle start pulse to the divider.
- div_opcode  out  2  funct3[1:0] passed to the divider.
- div_op1  out  32  registered operand A to the divider.
- div_op2  out  32  registered operand B to the divider.
- div_done  in  1  divider completion pulse.
- div_result  in  32  divider result, valid with div_done.
- stall  out  1  hold IF/ID/EX stages.
- res_valid  out  1  one-cycle writeback strobe.
- res_data  out  32  result value.
- res_rd  out  5  result destination tag.
- busy  out  1  a unit is in flight; includes the DRAIN state.
- timeout_err  out  1  one-cycle watchdog pulse.

Behaviour:
- Reset: all outputs are 0, state is IDLE, operand/opcode/tag registers are 0, the counter is 0. Reset mid-operation aborts immediately and produces no result. A unit done arriving after reset is ignored because the state is IDLE.
- States: IDLE, MUL_WAIT, DIV_WAIT, DRAIN, RESP.
- IDLE, accept condition:
  - Accept when ex_valid=1 and flush=0.
  - stall is asserted combinationally in the acceptance cycle.
  - The controller registers rs1, rs2, rd and funct3.
- IDLE, fast path (FAST_PATH=1): the result is resolved locally, the next state is RESP, and no start pulse is issued. Cases:
  - MUL*, either operand 0: result 0.
  - DIV/DIVU with rs2=0: result 0xFFFFFFFF.
  - REM/REMU with rs2=0: result rs1.
  - DIV with rs1=0x80000000 and rs2=0xFFFFFFFF: result 0x80000000.
  - REM with rs1=0x80000000 and rs2=0xFFFFFFFF: result 0.
- IDLE, otherwise:
  - Next cycle: mul_start or div_start is high for exactly one cycle, with the registered operands and opcode.
  - State becomes MUL_WAIT (funct3[2]=0) or DIV_WAIT (funct3[2]=1).
- Operand and opcode outputs are held stable from start until done.
- MUL_WAIT / DIV_WAIT:
  - stall=1, busy=1; the counter increments each cycle.
  - On the matching done: capture the result, go to RESP.
  - A done from the non-selected unit is ignored.
  - If the counter reaches MAX_CYCLES: timeout_err pulses, state returns to IDLE, no res_valid.
- RESP: res_valid=1 for one cycle with res_data and res_rd; stall=0 in this cycle; next state is IDLE.
- Back-to-back: a new ex_valid is accepted no earlier than the cycle after RESP. Minimum issue interval is 2 cycles for the fast path; for the unit path it is the unit latency + 3.
- flush:
  - In IDLE: blocks acceptance.
  - In a WAIT state: go to DRAIN.
  - In RESP: suppresses res_valid; state still returns to IDLE.
- DRAIN:
  - busy=1; stall=ex_valid, so a younger M-op waits.
  - Wait for the done of the in-flight unit, discard its result, go to IDLE.
  - The watchdog also applies here.
- Simultaneous flush and done in a WAIT state: flush wins; the result is discarded and the next state is IDLE, not DRAIN.
- No start pulse is ever issued while a unit is in flight.

Decomposition:
- Package m_ext_pkg holds:
  - funct3 localparams F3_MUL … F3_REMU.
  - The 2-bit unit opcode constants (MUL=00, MULH=01, MULHSU=10, MULHU=11, and the same encoding for the divider).
  - The state enum ctrl_state_t.
  - The constants INT_MIN=0x80000000 and ALL_ONES.
- One combinational sub-module, m_ext_special_case:
  - Inputs: funct3, rs1, rs2.
  - Outputs: hit, value.
  - Instantiated only when FAST_PATH=1.

Test Plan:
- MUL with rs1=7, rs2=6, multiplier model done after 33 cycles with 42 → one mul_start pulse, stall high for 35 cycles, res_valid with res_data=42 and the correct res_rd.
- MUL with rs1=0, rs2=0x1234 → no mul_start; res_valid 1 cycle after acceptance with res_data=0.
- DIVU with rs2=0 → res_data=0xFFFFFFFF. REM with rs1=0x80000000, rs2=0xFFFFFFFF → res_data=0. No div_start in either case.
- MULHU accepted, flush asserted 5 cycles later → DRAIN; mul_done later produces no res_valid; a following MUL (3×5) returns 15 with no second start pulse before the first done.
- DIV with the divider model never asserting done → timeout_err pulses exactly MAX_CYCLES cycles after entering DIV_WAIT; state returns to IDLE; stall drops.
- rst_n pulled low during MUL_WAIT → all outputs 0 immediately; the later mul_done is ignored; no res_valid.
